// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared configuration-field layout helpers for io_bank_cfg
// Field layout per channel, LSB first: sel[SEL_W-1:0], inv, reg_en.
package io_pkg;

    localparam int SEL_LSB = 0;

    // Bit position of the invert flag inside a channel field.
    function automatic int inv_bit(input int sel_w);
        return sel_w;
    endfunction

    // Bit position of the output-register enable inside a channel field.
    function automatic int reg_bit(input int sel_w);
        return sel_w + 1;
    endfunction

    // Total configuration chain length for num_ch channels.
    function automatic int cfg_len(input int num_ch);
        return num_ch * ($clog2(num_ch) + 2);
    endfunction

endpackage

// File: rtl/io_chan_mux.sv
// rtl/io_chan_mux.sv - one output channel: select, optional invert, optional register
// Ports:
//   clb_clk, rst_n : clock, asynchronous active-low reset
//   cfg_valid      : forces the channel output to zero while low
//   in_bus         : all input channels, channel c at [c*DATA_W +: DATA_W]
//   fld            : this channel's active configuration field
//   out_ch         : channel output
module io_chan_mux
    import io_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(NUM_CH),
    localparam int FLD_W  = SEL_W + 2
) (
    input  logic                     clb_clk,
    input  logic                     rst_n,
    input  logic                     cfg_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_bus,
    input  logic [FLD_W-1:0]         fld,
    output logic [DATA_W-1:0]        out_ch
);

    localparam int INV_B = inv_bit(SEL_W);
    localparam int REG_B = reg_bit(SEL_W);

    logic [SEL_W-1:0]  sel;
    logic              inv;
    logic              reg_en;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] q;

    assign sel    = fld[SEL_LSB +: SEL_W];
    assign inv    = fld[INV_B];
    assign reg_en = fld[REG_B];

    // A select code with no matching channel leaves d at zero, uninverted.
    always_comb begin
        d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(sel) == c) begin
                d = in_bus[c*DATA_W +: DATA_W] ^ {DATA_W{inv}};
            end
        end
    end

    // Free-running: the register tracks d every cycle whether or not it is selected.
    always_ff @(posedge clb_clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

    assign out_ch = !cfg_valid ? '0 : (reg_en ? q : d);

endmodule

// File: rtl/io_bank_cfg.sv
// rtl/io_bank_cfg.sv - serially configured NUM_CH x DATA_W IO routing bank
// Optional macro IO_SYNC2_EN: 2-flop synchroniser on every in_bus bit.
// Ports:
//   clb_clk, rst_n : clock, asynchronous active-low reset
//   prog_in        : serial config bit, LSB first
//   prog_en        : shift enable; falling edge requests a commit
//   prog_out       : shadow[0], daisy-chain output
//   prog_done      : one-cycle pulse, commit accepted
//   prog_err       : one-cycle pulse, commit rejected (wrong bit count)
//   cfg_valid      : high once any commit has been accepted
//   in_bus/out_bus : NUM_CH channels of DATA_W bits each
module io_bank_cfg
    import io_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clb_clk,
    input  logic                     rst_n,
    input  logic                     prog_in,
    input  logic                     prog_en,
    output logic                     prog_out,
    output logic                     prog_done,
    output logic                     prog_err,
    output logic                     cfg_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_bus,
    output logic [NUM_CH*DATA_W-1:0] out_bus
);

    localparam int SEL_W = $clog2(NUM_CH);
    localparam int FLD_W = SEL_W + 2;
    localparam int CFG_W = cfg_len(NUM_CH);
    localparam int CNT_W = $clog2(CFG_W + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_W + 1);

    logic [CFG_W-1:0]         shadow;
    logic [CFG_W-1:0]         active;
    logic [CNT_W-1:0]         cnt;
    logic                     prog_en_q;
    logic                     commit_req;
    logic [NUM_CH*DATA_W-1:0] mux_in;

    assign commit_req = prog_en_q & ~prog_en;

    // The counter saturates one past CFG_W so an overlong stream can never
    // wrap back onto the exact length and be accepted.
    always_ff @(posedge clb_clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            active    <= '0;
            cnt       <= '0;
            prog_en_q <= 1'b0;
            prog_done <= 1'b0;
            prog_err  <= 1'b0;
            cfg_valid <= 1'b0;
        end else begin
            prog_en_q <= prog_en;
            prog_done <= 1'b0;
            prog_err  <= 1'b0;
            if (commit_req) begin
                cnt <= '0;
                if (cnt == CNT_FULL) begin
                    active    <= shadow;
                    prog_done <= 1'b1;
                    cfg_valid <= 1'b1;
                end else begin
                    prog_err <= 1'b1;
                end
            end else if (prog_en) begin
                shadow <= {prog_in, shadow[CFG_W-1:1]};
                if (cnt != CNT_SAT) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign prog_out = shadow[0];

`ifdef IO_SYNC2_EN
    logic [NUM_CH*DATA_W-1:0] sync_q1;
    logic [NUM_CH*DATA_W-1:0] sync_q2;

    always_ff @(posedge clb_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= in_bus;
            sync_q2 <= sync_q1;
        end
    end

    assign mux_in = sync_q2;
`else
    assign mux_in = in_bus;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        io_chan_mux #(
            .NUM_CH (NUM_CH),
            .DATA_W (DATA_W)
        ) u_mux (
            .clb_clk   (clb_clk),
            .rst_n     (rst_n),
            .cfg_valid (cfg_valid),
            .in_bus    (mux_in),
            .fld       (active[c*FLD_W +: FLD_W]),
            .out_ch    (out_bus[c*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_io_bank_cfg.sv
// tb/tb_io_bank_cfg.sv - self-checking bench for io_bank_cfg
module tb_io_bank_cfg;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int CFG_W  = 16;
`ifdef IO_SYNC2_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic        clb_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        prog_in = 1'b0;
    logic        prog_en = 1'b0;
    logic        prog_out, prog_done, prog_err, cfg_valid;
    logic [31:0] in_bus  = '0;
    logic [31:0] out_bus;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clb_clk = ~clb_clk;

    io_bank_cfg #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clb_clk   (clb_clk),
        .rst_n     (rst_n),
        .prog_in   (prog_in),
        .prog_en   (prog_en),
        .prog_out  (prog_out),
        .prog_done (prog_done),
        .prog_err  (prog_err),
        .cfg_valid (cfg_valid),
        .in_bus    (in_bus),
        .out_bus   (out_bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_hist[$];       // last CFG_W bits ever shifted, oldest first
    logic [15:0] m_act;
    bit          m_valid, m_done, m_err, m_en_q;
    int          m_cnt;            // true count, never saturates
    logic [7:0]  m_regq [NUM_CH];
    logic [31:0] m_s1, m_s2;

    function automatic logic [7:0] dch(input int ch, input logic [15:0] act, input logic [31:0] inb);
        logic [3:0] f;
        int         s;
        f = act[ch*4 +: 4];
        s = int'(f[1:0]);
        return inb[s*8 +: 8] ^ (f[2] ? 8'hFF : 8'h00);
    endfunction

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < CFG_W; i++) m_hist.push_back(1'b0);
        m_act = '0; m_valid = 0; m_done = 0; m_err = 0; m_en_q = 0; m_cnt = 0;
        m_s1 = '0; m_s2 = '0;
        for (int c = 0; c < NUM_CH; c++) m_regq[c] = '0;
    endtask

    task automatic model_edge();
        logic [31:0] eff;
        eff = (SYNC_LAT != 0) ? m_s2 : in_bus;
        for (int c = 0; c < NUM_CH; c++) m_regq[c] = dch(c, m_act, eff);
        m_s2 = m_s1;
        m_s1 = in_bus;
        m_done = 0;
        m_err  = 0;
        if (m_en_q && !prog_en) begin
            if (m_cnt == CFG_W) begin
                for (int i = 0; i < CFG_W; i++) m_act[i] = m_hist[i];
                m_valid = 1;
                m_done  = 1;
            end else begin
                m_err = 1;
            end
            m_cnt = 0;
        end else if (prog_en) begin
            m_hist.push_back(prog_in);
            void'(m_hist.pop_front());
            m_cnt++;
        end
        m_en_q = prog_en;
    endtask

    function automatic logic [31:0] exp_out();
        logic [31:0] r;
        logic [3:0]  f;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            f = m_act[c*4 +: 4];
            if (!m_valid)  r[c*8 +: 8] = 8'h00;
            else if (f[3]) r[c*8 +: 8] = m_regq[c];
            else           r[c*8 +: 8] = dch(c, m_act, (SYNC_LAT != 0) ? m_s2 : in_bus);
        end
        return r;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clb_clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_edge();
        end
    end

    // Compare every cycle, mid-period.
    initial begin
        forever begin
            @(negedge clb_clk);
            if (rst_n) begin
                chk("out_bus", 64'(out_bus), 64'(exp_out()));
                chk("flags{out,done,err,valid}", 64'({prog_out, prog_done, prog_err, cfg_valid}),
                    64'({m_hist[0], m_done, m_err, m_valid}));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clb_clk);
        #1;
    endtask

    task automatic shift_bits(input logic [63:0] v, input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            prog_en = 1'b1;
            prog_in = v[i];
            if (rnd) in_bus = $urandom;
            tick();
        end
    endtask

    task automatic drop(input bit rnd);
        prog_en = 1'b0;
        prog_in = 1'b0;
        if (rnd) in_bus = $urandom;
        tick();
    endtask

    localparam logic [31:0] IN_A = 32'h44332211;
    localparam logic [31:0] IN_B = 32'h0C0B0A09;

    logic [15:0] cap;
    int          lat_c, lat_r;

    initial begin
        in_bus = IN_A;
        repeat (3) tick();
        chk("reset_out_bus", 64'(out_bus), 64'h0);
        chk("reset_valid", 64'(cfg_valid), 64'h0);
        rst_n = 1'b1;
        tick();

        // Good commit
        shift_bits(64'h2943, 16, 0);
        drop(0);
        chk("good_done", 64'(prog_done), 64'h1);
        chk("good_valid", 64'(cfg_valid), 64'h1);
        chk("good_out0", 64'(out_bus[7:0]), 64'h44);
        chk("good_out1", 64'(out_bus[15:8]), 64'hEE);
        chk("good_out3", 64'(out_bus[31:24]), 64'h33);
        tick();
        chk("good_done_clr", 64'(prog_done), 64'h0);
        chk("good_out2", 64'(out_bus[23:16]), 64'h22);

        // Latency of comb (ch0, sel3) and reg (ch2, sel1) paths
        in_bus = IN_B;
        #1;
        lat_c = -1;
        lat_r = -1;
        for (int k = 0; k < 8; k++) begin
            if (lat_c < 0 && out_bus[7:0] == 8'h0C)   lat_c = k;
            if (lat_r < 0 && out_bus[23:16] == 8'h0A) lat_r = k;
            tick();
        end
        chk("lat_comb", 64'(lat_c), 64'(SYNC_LAT));
        chk("lat_reg", 64'(lat_r), 64'(SYNC_LAT + 1));
        in_bus = IN_A;
        repeat (4) tick();

        // Short bitstream
        shift_bits(64'hFFFF, 15, 0);
        drop(0);
        chk("short_err", 64'(prog_err), 64'h1);
        chk("short_done", 64'(prog_done), 64'h0);
        chk("short_valid", 64'(cfg_valid), 64'h1);
        chk("short_out0", 64'(out_bus[7:0]), 64'h44);
        chk("short_out1", 64'(out_bus[15:8]), 64'hEE);
        tick();

        // Long bitstream
        shift_bits(64'h00_0000_1234_0000, 40, 0);
        drop(0);
        chk("long_err", 64'(prog_err), 64'h1);
        chk("long_out0", 64'(out_bus[7:0]), 64'h44);
        tick();

        // Daisy chain: prog_out replays the first 16 bits 16 cycles later
        cap = '0;
        for (int i = 0; i < 32; i++) begin
            if (i >= 16) cap[i-16] = prog_out;
            prog_en = 1'b1;
            prog_in = (i < 16) ? 1'((32'hA5A51234 >> i) & 1) : 1'((32'hA5A51234 >> i) & 1);
            tick();
        end
        chk("daisy_replay", 64'(cap), 64'h1234);
        drop(0);
        chk("daisy_err", 64'(prog_err), 64'h1);
        tick();

        // Live traffic while reshifting, then immediate reassert
        shift_bits(64'h6C5A, 16, 1);
        drop(1);
        chk("live_done", 64'(prog_done), 64'h1);
        for (int i = 0; i < 5; i++) begin
            in_bus = $urandom;
            tick();
        end
        shift_bits(64'h6C5A, 3, 1);
        drop(1);
        shift_bits(64'h2943, 16, 1);
        drop(1);
        chk("reassert_done", 64'(prog_done), 64'h1);
        repeat (4) begin
            in_bus = $urandom;
            tick();
        end

        // Asynchronous reset mid-shift
        in_bus = IN_A;
        shift_bits(64'h0, 8, 0);
        chk("pre_reset_prog_out", 64'(prog_out), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("async_out_bus", 64'(out_bus), 64'h0);
        chk("async_flags", 64'({prog_out, prog_done, prog_err, cfg_valid}), 64'h0);
        prog_en = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        shift_bits(64'h2943, 16, 0);
        drop(0);
        chk("post_reset_done", 64'(prog_done), 64'h1);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/io_bank_cfg.md
Name: io_bank_cfg

Overview:
- Parametrised next-generation FPGA IO block: NUM_CH channels of DATA_W bits.
- Each output channel is routed from any input channel through a serially programmed configuration chain.
- Per-channel options: inversion and an optional output register.
- Configuration is shifted into a shadow chain, length-checked, then committed atomically, so live IO routing is never corrupted by a partial bitstream.

Parameters:
- NUM_CH, 4, number of input and output channels (≥2).
- DATA_W, 8, bits per channel.
- Derived (localparam): SEL_W = clog2(NUM_CH); FLD_W = SEL_W+2; CFG_W = NUM_CH*FLD_W.

Ports:
- clb_clk  in  1  sole clock; programming and datapath.
- rst_n  in  1  asynchronous, active-low reset.
- prog_in  in  1  serial config bit, LSB first.
- prog_en  in  1  shift enable; its falling edge requests a commit.
- prog_out  out  1  serial chain output, shadow[0], for daisy-chaining.
- prog_done  out  1  one-cycle pulse: commit succeeded.
- prog_err  out  1  one-cycle pulse: commit rejected due to wrong bit count.
- cfg_valid  out  1  high once any commit has succeeded.
- in_bus  in  NUM_CH*DATA_W  channel c = in_bus[c*DATA_W +: DATA_W].
- out_bus  out  NUM_CH*DATA_W  same slicing.

Behaviour:
- Reset (async, rst_n=0): shadow, active config, bit counter, prog_en_q, output registers, prog_done, prog_err and cfg_valid all 0. out_bus=0.
- Shift: on each clb_clk edge with prog_en=1:
  - shadow <= {prog_in, shadow[CFG_W-1:1]}.
  - cnt <= cnt+1, saturating at CFG_W+1.
  - prog_out = shadow[0], registered, so it is the bit shifted out.
- Commit: when prog_en_q=1 and prog_en=0 (falling edge seen in the same cycle):
  - If cnt==CFG_W: active <= shadow; prog_done=1 for the next cycle; cfg_valid <= 1.
  - Otherwise: active is unchanged and prog_err=1 for the next cycle.
  - cnt <= 0 in both cases. The shadow is not cleared.
- Reasserting prog_en the cycle after deassert is legal; the new sequence counts from 0.
- The active config is untouched while shifting, so the datapath keeps running on the old config.
- Field for channel c at active[c*FLD_W +: FLD_W]:
  - bits [SEL_W-1:0] = sel
  - bit SEL_W = inv
  - bit SEL_W+1 = reg_en
- Channel data: d_c = in[sel] ^ {DATA_W{inv}}. If sel ≥ NUM_CH (NUM_CH not a power of 2), d_c = 0.
- reg_en=0: out_c = d_c combinationally, 0-cycle latency.
- reg_en=1: out_c = flop of d_c, 1-cycle latency. The flop updates every cycle.
- cfg_valid=0 forces out_bus=0 regardless of active.
- A commit takes effect on the edge after the falling edge is detected. The output register then holds its previously captured value for one cycle.

Optional Feature:
- Macro: IO_SYNC2_EN.
- Defined: each in_bus bit passes a 2-flop synchroniser (reset 0) before the mux. This adds 2 cycles to both latencies (comb path → 2, reg path → 3).
- Undefined: no synchroniser; latencies as in Behaviour.

Decomposition:
- Shared package io_pkg holds:
  - field offset localparams SEL_LSB=0, INV_BIT=SEL_W, REG_BIT=SEL_W+1 (functions of SEL_W);
  - a function cfg_len(num_ch) returning num_ch*(clog2(num_ch)+2).
- One natural sub-module, io_chan_mux: one output channel's select, invert and optional register. It is instantiated NUM_CH times in a generate loop.
- Shift chain, counter and commit logic stay in the top.

Test Plan (NUM_CH=4, DATA_W=8, CFG_W=16):
- Reset: assert rst_n=0 mid-shift → all outputs, cfg_valid and prog_out are 0 immediately, with no clock edge.
- Good commit: shift 0x2943 LSB first, 16 cycles, then drop prog_en. Inputs in0..3 = 11,22,33,44 (hex).
  - prog_done pulses once; cfg_valid=1.
  - out0=0x44 and out1=0xEE (combinational).
  - out2=0x22 one cycle later; out3=0x33.
- Short bitstream: shift 15 bits, drop prog_en → prog_err pulse; out_bus still reflects 0x2943; cfg_valid stays 1.
- Long bitstream: shift 40 bits → prog_err; counter saturation causes no wraparound false-accept.
- Daisy chain: shift 32 bits with the pattern 0xA5A5_1234 → prog_out replays the first 16 bits delayed by 16 cycles.
- Live traffic during reshift: toggle in_bus every cycle while shifting a new config → out_bus follows the old config until the commit edge, then the new one. With IO_SYNC2_EN, latencies measure 2 (comb) and 3 (reg).
